// File: rtl/fm_spy_buffer.sv
// Circular spy buffer: captures in_data until frozen by software (or by trig when FM_SPY_TRIG_EN is defined),
// then offers 1-cycle-latency random readback and an oldest-first playback stream; no backpressure, in_valid is never stalled.
module fm_spy_buffer #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10
) (
  input  logic              clk_hs,
  input  logic              rst_hs,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              freeze_req,
`ifdef FM_SPY_TRIG_EN
  input  logic              trig,
`endif
  input  logic [ADDR_W-1:0] post_trig,
  input  logic [1:0]        pb_mode,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              frozen,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              wrapped,
  output logic [DATA_W-1:0] pb_data,
  output logic              pb_valid
);

  localparam logic [1:0] ST_SPY    = 2'd0;
  localparam logic [1:0] ST_POST   = 2'd1;
  localparam logic [1:0] ST_FROZEN = 2'd2;
  localparam logic [1:0] ST_PLAY   = 2'd3;

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  logic [1:0]        state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] pb_addr;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] last_addr;
  logic              pb_hold;
  logic              capturing;
  logic              wr_en;
  logic              mode_once;
  logic              mode_loop;
  logic              buf_nonempty;

`ifdef FM_SPY_TRIG_EN
  logic [ADDR_W-1:0] cnt;
  assign capturing = (state == ST_SPY) || (state == ST_POST);
`else
  logic unused_post_trig;
  assign unused_post_trig = ^post_trig;
  assign capturing = (state == ST_SPY);
`endif

  assign wr_en        = capturing && in_valid && !rst_hs;
  assign start_addr   = wrapped ? wr_ptr : '0;
  assign last_addr    = wr_ptr - PTR_ONE;
  assign mode_once    = (pb_mode == 2'b01);
  assign mode_loop    = (pb_mode == 2'b10);
  assign buf_nonempty = wrapped || (wr_ptr != '0);
  assign frozen       = (state == ST_FROZEN) || (state == ST_PLAY);

  // Storage is never reset so it maps onto a plain RAM.
  always_ff @(posedge clk_hs) begin
    if (wr_en) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk_hs) begin
    if (rst_hs) begin
      state    <= ST_SPY;
      wr_ptr   <= '0;
      wrapped  <= 1'b0;
      pb_valid <= 1'b0;
      pb_data  <= '0;
      rd_data  <= '0;
      pb_addr  <= '0;
      pb_hold  <= 1'b0;
`ifdef FM_SPY_TRIG_EN
      cnt      <= '0;
`endif
    end else begin
      rd_data  <= mem[start_addr + rd_addr];
      pb_valid <= 1'b0;

      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        if (wr_ptr == PTR_MAX) begin
          wrapped <= 1'b1;
        end
      end

      case (state)
        ST_SPY: begin
          if (freeze_req) begin
            state <= ST_FROZEN;
`ifdef FM_SPY_TRIG_EN
          end else if (trig) begin
            if (post_trig == '0) begin
              state <= ST_FROZEN;
            end else begin
              cnt   <= post_trig;
              state <= ST_POST;
            end
`endif
          end
        end

`ifdef FM_SPY_TRIG_EN
        ST_POST: begin
          if (freeze_req) begin
            state <= ST_FROZEN;
          end else if (in_valid) begin
            cnt <= cnt - PTR_ONE;
            if (cnt == PTR_ONE) begin
              state <= ST_FROZEN;
            end
          end
        end
`endif

        ST_FROZEN: begin
          // pb_hold stops a finished once-playback from restarting until the mode changes.
          if (!mode_once) begin
            pb_hold <= 1'b0;
          end
          if ((mode_loop || (mode_once && !pb_hold)) && buf_nonempty) begin
            state   <= ST_PLAY;
            pb_addr <= start_addr;
          end else if (!freeze_req && !mode_once && !mode_loop) begin
            state   <= ST_SPY;
            wrapped <= 1'b0;
          end
        end

        ST_PLAY: begin
          if (!mode_once && !mode_loop) begin
            state <= ST_FROZEN;
          end else begin
            pb_data  <= mem[pb_addr];
            pb_valid <= 1'b1;
            if (pb_addr == last_addr) begin
              if (mode_loop) begin
                pb_addr <= start_addr;
              end else begin
                state   <= ST_FROZEN;
                pb_hold <= 1'b1;
              end
            end else begin
              pb_addr <= pb_addr + PTR_ONE;
            end
          end
        end

        default: state <= ST_SPY;
      endcase
    end
  end

endmodule

// File: tb/tb_fm_spy_buffer.sv
// Directed bench for fm_spy_buffer at DATA_W=8, ADDR_W=4; trigger scenarios run only when FM_SPY_TRIG_EN is defined.
module tb_fm_spy_buffer;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  logic              clk_hs;
  logic              rst_hs;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              freeze_req;
`ifdef FM_SPY_TRIG_EN
  logic              trig;
`endif
  logic [ADDR_W-1:0] post_trig;
  logic [1:0]        pb_mode;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              frozen;
  logic [ADDR_W-1:0] wr_ptr;
  logic              wrapped;
  logic [DATA_W-1:0] pb_data;
  logic              pb_valid;

  int errors = 0;
  int checks = 0;

  fm_spy_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_hs     (clk_hs),
    .rst_hs     (rst_hs),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .freeze_req (freeze_req),
`ifdef FM_SPY_TRIG_EN
    .trig       (trig),
`endif
    .post_trig  (post_trig),
    .pb_mode    (pb_mode),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frozen     (frozen),
    .wr_ptr     (wr_ptr),
    .wrapped    (wrapped),
    .pb_data    (pb_data),
    .pb_valid   (pb_valid)
  );

  initial clk_hs = 1'b0;
  always #5 clk_hs = ~clk_hs;

  task automatic tick();
    @(posedge clk_hs);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_hs = 1'b1;
    tick();
    tick();
    rst_hs = 1'b0;
  endtask

  initial begin
    rst_hs = 1'b1; in_data = '0; in_valid = 1'b0; freeze_req = 1'b0;
`ifdef FM_SPY_TRIG_EN
    trig = 1'b0;
`endif
    post_trig = '0; pb_mode = 2'b00; rd_addr = '0;

    // Reset state
    tick(); tick();
    chk("rst_frozen", 32'(frozen), 32'd0);
    chk("rst_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("rst_wrapped", 32'(wrapped), 32'd0);
    chk("rst_pb_valid", 32'(pb_valid), 32'd0);
    chk("rst_pb_data", 32'(pb_data), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    rst_hs = 1'b0;

    // 20 samples into a 16-deep buffer, freeze on the last one
    for (int i = 0; i < 20; i++) begin
      in_data = DATA_W'(i); in_valid = 1'b1; freeze_req = (i == 19);
      tick();
      if (i == 14) chk("wrap_before", 32'(wrapped), 32'd0);
      if (i == 15) begin
        chk("wrap_after", 32'(wrapped), 32'd1);
        chk("wrap_ptr0", 32'(wr_ptr), 32'd0);
      end
    end
    chk("fr20_frozen", 32'(frozen), 32'd1);
    chk("fr20_wrapped", 32'(wrapped), 32'd1);
    chk("fr20_wr_ptr", 32'(wr_ptr), 32'd4);
    in_data = 8'hAA;
    rd_addr = 4'd0;
    tick();
    chk("fr20_no_write", 32'(wr_ptr), 32'd4);
    chk("rd_oldest", 32'(rd_data), 32'd4);
    in_valid = 1'b0;
    rd_addr = 4'd15;
    tick();
    chk("rd_newest", 32'(rd_data), 32'd19);
    rd_addr = 4'd3;
    tick();
    chk("rd_mid", 32'(rd_data), 32'd7);

    // Release to SPY: wr_ptr kept, wrapped cleared
    freeze_req = 1'b0;
    tick();
    chk("unfreeze_frozen", 32'(frozen), 32'd0);
    chk("unfreeze_wrapped", 32'(wrapped), 32'd0);
    chk("unfreeze_wr_ptr", 32'(wr_ptr), 32'd4);

    // freeze_req (with trig, if present) and post_trig=7: frozen next cycle
    post_trig = 4'd7; freeze_req = 1'b1; in_valid = 1'b1; in_data = 8'h50;
`ifdef FM_SPY_TRIG_EN
    trig = 1'b1;
`endif
    tick();
`ifdef FM_SPY_TRIG_EN
    trig = 1'b0;
`endif
    chk("frz_trig_frozen", 32'(frozen), 32'd1);
    chk("frz_trig_wr_ptr", 32'(wr_ptr), 32'd5);
    in_valid = 1'b0;
    freeze_req = 1'b0;
    tick();
    chk("frz_trig_release", 32'(frozen), 32'd0);

`ifdef FM_SPY_TRIG_EN
    // trig on sample 5, three more samples, then frozen
    do_reset();
    post_trig = 4'd3;
    for (int i = 0; i < 10; i++) begin
      in_data = DATA_W'(i); in_valid = 1'b1; trig = (i == 5);
      tick();
      if (i == 7) chk("post_not_yet", 32'(frozen), 32'd0);
      if (i == 8) begin
        chk("post_frozen", 32'(frozen), 32'd1);
        chk("post_wr_ptr", 32'(wr_ptr), 32'd9);
      end
    end
    trig = 1'b0; in_valid = 1'b0;
    chk("post_hold_ptr", 32'(wr_ptr), 32'd9);
    rd_addr = 4'd8;
    tick();
    chk("post_last_word", 32'(rd_data), 32'd8);
`endif

    // Empty buffer: playback request stays FROZEN
    do_reset();
    freeze_req = 1'b1;
    tick();
    pb_mode = 2'b01;
    tick(); tick(); tick();
    chk("empty_pb_valid", 32'(pb_valid), 32'd0);
    chk("empty_frozen", 32'(frozen), 32'd1);
    pb_mode = 2'b00; freeze_req = 1'b0;
    tick();

    // Six samples then playback-once
    do_reset();
    for (int i = 0; i < 6; i++) begin
      in_data = DATA_W'(i); in_valid = 1'b1; freeze_req = (i == 5);
      tick();
    end
    in_valid = 1'b0;
    chk("six_wr_ptr", 32'(wr_ptr), 32'd6);
    pb_mode = 2'b01;
    tick();
    chk("once_lat", 32'(pb_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("once_valid", 32'(pb_valid), 32'd1);
      chk("once_data", 32'(pb_data), 32'(i));
    end
    tick();
    chk("once_end_valid", 32'(pb_valid), 32'd0);
    chk("once_end_hold", 32'(pb_data), 32'd5);
    chk("once_end_frozen", 32'(frozen), 32'd1);
    tick();
    chk("once_no_replay", 32'(pb_valid), 32'd0);

    // Playback-loop, gap-free wrap back to the oldest word
    pb_mode = 2'b10;
    tick();
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("loop_valid", 32'(pb_valid), 32'd1);
      chk("loop_data", 32'(pb_data), 32'(i % 6));
    end
    pb_mode = 2'b00;
    tick();
    chk("loop_stop_valid", 32'(pb_valid), 32'd0);
    chk("loop_stop_frozen", 32'(frozen), 32'd1);

    // Reset in the middle of playback-loop
    pb_mode = 2'b10;
    tick(); tick(); tick();
    chk("loop2_valid", 32'(pb_valid), 32'd1);
    rst_hs = 1'b1; freeze_req = 1'b0; pb_mode = 2'b00;
    tick();
    chk("pbrst_valid", 32'(pb_valid), 32'd0);
    chk("pbrst_frozen", 32'(frozen), 32'd0);
    chk("pbrst_wr_ptr", 32'(wr_ptr), 32'd0);
    rst_hs = 1'b0; in_data = 8'h77; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pbrst_ptr1", 32'(wr_ptr), 32'd1);
    rd_addr = 4'd0;
    tick();
    chk("pbrst_addr0", 32'(rd_data), 32'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fm_spy_buffer.md
FM_SPY_BUFFER -- requirements
Module: fm_spy_buffer

Interface
REQ-001 Parameter DATA_W, default 64, width of one spied sample.
REQ-002 Parameter ADDR_W, default 10, buffer depth = 2**ADDR_W samples.
REQ-003 clk_hs  in  1  sole clock; all logic on its rising edge.
REQ-004 rst_hs  in  1  reset, synchronous, active-high.
REQ-005 in_data  in  DATA_W  sample to capture.
REQ-006 in_valid  in  1  in_data qualifier.
REQ-007 freeze_req  in  1  level; software freeze request.
REQ-008 trig  in  1  single-cycle hardware trigger (present only with FM_SPY_TRIG_EN).
REQ-009 post_trig  in  ADDR_W  samples written after trigger before freezing.
REQ-010 pb_mode  in  2  00 spy, 01 playback-once, 10 playback-loop, 11 treated as 00.
REQ-011 rd_addr  in  ADDR_W  readback index relative to oldest sample.
REQ-012 rd_data  out  DATA_W  readback word.
REQ-013 frozen  out  1  high in FROZEN and PLAYBACK states.
REQ-014 wr_ptr  out  ADDR_W  next write location.
REQ-015 wrapped  out  1  buffer has been filled at least once since last SPY entry.
REQ-016 pb_data  out  DATA_W, pb_valid  out  1  playback stream.

Function
REQ-017 States SPY, POST, FROZEN, PLAYBACK; single-port write, independent read port.
REQ-018 SPY/POST: in_valid=1 writes in_data at wr_ptr, wr_ptr increments mod 2**ADDR_W; wrap 2**ADDR_W-1 -> 0 sets wrapped.
REQ-019 SPY, freeze_req=1: that cycle's valid sample is written; FROZEN next cycle.
REQ-020 SPY, trig=1, freeze_req=0: cnt<=post_trig, go POST; post_trig=0 -> FROZEN directly; trig-cycle sample is written, not counted.
REQ-021 POST: each write decrements cnt; write with cnt=1 -> FROZEN next cycle; freeze_req=1 -> FROZEN next cycle (software priority).
REQ-022 trig ignored outside SPY; trig and freeze_req same cycle -> freeze_req wins.
REQ-023 FROZEN: no writes; freeze_req=0 and pb_mode=00 -> SPY, wr_ptr kept, wrapped cleared.
REQ-024 FROZEN, pb_mode 01/10: PLAYBACK if buffer non-empty (wrapped=1 or wr_ptr!=0), else stay FROZEN.
REQ-025 PLAYBACK start address: wr_ptr if wrapped else 0; one word per cycle, pb_valid=1, first word 2 cycles after mode seen.
REQ-026 Last word is location wr_ptr-1; once-mode -> FROZEN; loop-mode restarts at start address with no gap cycle.
REQ-027 pb_mode=00 during PLAYBACK -> pb_valid=0 next cycle, FROZEN.
REQ-028 rd_data = mem[(start address + rd_addr) mod depth], 1-cycle latency, valid in every state; write-same-address returns old data.
REQ-029 pb_data holds last value when pb_valid=0.

Reset
REQ-030 rst_hs=1: state SPY, wr_ptr=0, cnt=0, wrapped=0, frozen=0, pb_valid=0, pb_data=0, rd_data=0; memory not cleared.
REQ-031 Reset mid-POST or mid-PLAYBACK aborts immediately; first post-reset sample written at address 0.

Configuration
REQ-032 Macro FM_SPY_TRIG_EN defined: trig port, POST state and cnt present per REQ-020/021.
REQ-033 FM_SPY_TRIG_EN undefined: trig port absent, POST unreachable and not synthesised, post_trig present but ignored.

Verification
REQ-034 ADDR_W=4, 20 valid samples 0..19, freeze_req -> frozen=1, wrapped=1, wr_ptr=4, rd_addr=0 gives 4, rd_addr=15 gives 19.
REQ-035 trig on sample 5, post_trig=3 -> last written sample 8, frozen next cycle, wr_ptr=9.
REQ-036 6 samples, freeze, pb_mode=01 -> pb_valid for 6 cycles, data 0..5, then FROZEN; pb_mode=10 -> 0..5 repeating gap-free.
REQ-037 trig and freeze_req same cycle with post_trig=7 -> FROZEN next cycle, no POST.
REQ-038 rst_hs during playback-loop -> pb_valid=0, frozen=0, wr_ptr=0 next cycle; next sample lands at address 0.
